seq_divider: RTL

//  Multi-cycle unsigned restoring divider: computes quotient/remainder of two bits-wide operands.
//  One subtract-and-shift step per clock, in place of the ripple add path.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_trial_subtractor.sv | 44 ++++
 rtl/seq_divider.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Provides the FSM state encoding and the step-counter width helper.
package div_pkg;

  // Divider control states: accept operands, iterate, present result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter must hold the value 'w' (the number of remaining steps).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_trial_subtractor.sv
// Trial subtractor for the restoring divider: diff = a - b built as
// a + ~b + 1 on a ripple chain of full adders. no_borrow is the final carry.

// One-bit full adder cell used to build the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module trial_subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);
  logic [W:0] carry_s;

  // Carry-in of one completes the two's-complement negation of b.
  assign carry_s[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_chain
      full_adder u_fa (
        .a  (a[i]),
        .b  (~b[i]),
        .ci (carry_s[i]),
        .s  (diff[i]),
        .co (carry_s[i+1])
      );
    end
  endgenerate

  // A final carry of one means a >= b, so the trial result is kept.
  assign no_borrow = carry_s[W];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one shift/subtract
// step per clock, operands and results on valid/ready handshakes.
// Optional feature macro: DIV_ZERO_CHECK_EN -- a zero divisor skips the
// iteration and raises div_zero alongside the saturated result.
module seq_divider
  import div_pkg::*;
#(
  parameter int bits = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bits-1:0] dividend,
  input  logic [bits-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [bits-1:0] quotient,
  output logic [bits-1:0] remainder,
  output logic            div_zero
);

  localparam int CW = cnt_width(bits);

  state_e            state_q, state_d;
  logic [bits:0]     r_q, r_d;      // partial remainder, one bit wider than operands
  logic [bits-1:0]   q_q, q_d;      // dividend shifting out / quotient shifting in
  logic [bits-1:0]   d_q, d_d;      // latched divisor
  logic [CW-1:0]     cnt_q, cnt_d;  // steps still to perform
`ifdef DIV_ZERO_CHECK_EN
  logic              dz_q, dz_d;
`endif

  logic [2*bits:0]   shift_s;       // {R,Q} shifted left by one, MSB of R dropped
  logic [bits:0]     shift_r_s;
  logic [bits-1:0]   shift_q_s;
  logic [bits:0]     diff_s;
  logic              no_borrow_s;

  // The partial remainder is always below the divisor, so dropping R's MSB loses nothing.
  assign shift_s   = (2*bits+1)'({r_q, q_q} << 1);
  assign shift_r_s = shift_s[2*bits:bits];
  assign shift_q_s = shift_s[bits-1:0];

  trial_subtractor #(.W(bits + 1)) u_sub (
    .a         (shift_r_s),
    .b         ({1'b0, d_q}),
    .diff      (diff_s),
    .no_borrow (no_borrow_s)
  );

  // Next-state logic: handshake acceptance, one division step per RUN cycle, result release.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = {(bits+1){1'b0}};
          cnt_d   = CW'(bits);
          state_d = S_RUN;
`ifdef DIV_ZERO_CHECK_EN
          if (divisor == {bits{1'b0}}) begin
            // Short-circuit to the same result a full run would produce.
            q_d     = {bits{1'b1}};
            r_d     = {1'b0, dividend};
            cnt_d   = {CW{1'b0}};
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            dz_d    = 1'b0;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Restore by simply not taking the difference when the subtract borrows.
        if (no_borrow_s) begin
          r_d = diff_s;
        end else begin
          r_d = shift_r_s;
        end
        q_d   = shift_q_s | {{(bits-1){1'b0}}, no_borrow_s};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
`ifdef DIV_ZERO_CHECK_EN
          dz_d    = 1'b0;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset drops any in-flight division.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= {(bits+1){1'b0}};
      q_q     <= {bits{1'b0}};
      d_q     <= {bits{1'b0}};
      cnt_q   <= {CW{1'b0}};
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = q_q;
  assign remainder = r_q[bits-1:0];
`ifdef DIV_ZERO_CHECK_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule
